// File: rtl/id_feeder.sv
// ---------------------------------------------------------------------------
// id_feeder
//   Upstream stage of the ID checker. Takes one complete ID per request
//   (letter index + nine BCD digits), maps the letter to its two-digit area
//   code, streams ten beats (area code, d1..d9) into the checker, waits for
//   the checker verdict and hands it back over a valid/ready response channel.
//
//   Parameters
//     TIMEOUT_CYCLES   max cycles spent waiting for chk_out_valid (>=2)
//
//   Optional feature (compile-time macro)
//     IDF_FORMAT_CHECK_EN  when defined, a letter index >25 or any digit >9
//                          aborts the request with resp_err=1 and no beats.
//
//   Ports
//     clk, rst_n         clock, asynchronous active-low reset
//     req_valid/ready    request handshake (ready only in IDLE)
//     req_letter         letter index, A=0 .. Z=25
//     req_digits         d1 at [35:32] .. d9 at [3:0], BCD
//     chk_in_valid/id    beat stream to the checker
//     chk_out_valid      checker verdict strobe, chk_out_legal_id verdict
//     resp_valid/ready   response handshake
//     resp_legal         1 = ID legal (meaningful only with resp_err=0)
//     resp_err           1 = aborted (format error or timeout)
// ---------------------------------------------------------------------------
module id_feeder #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_letter,
    input  logic [35:0] req_digits,
    output logic        chk_in_valid,
    output logic [5:0]  chk_in_id,
    input  logic        chk_out_valid,
    input  logic        chk_out_legal_id,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_legal,
    output logic        resp_err
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, SEND, WAIT, RESP} state_t;

    typedef struct packed {
        logic valid;
        logic legal;
        logic err;
    } resp_t;

    state_t        state_q, state_d;
    logic [3:0]    beat_q, beat_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [35:0]   dig_q, dig_d;
    logic          req_ready_d;
    logic          civ_d;
    logic [5:0]    cid_d;
    resp_t         resp_q, resp_d;
    logic          fmt_err;

    function automatic logic [5:0] area_code(input logic [4:0] l);
        logic [5:0] a;
        case (l)
            5'd0:    a = 6'd10;
            5'd1:    a = 6'd11;
            5'd2:    a = 6'd12;
            5'd3:    a = 6'd13;
            5'd4:    a = 6'd14;
            5'd5:    a = 6'd15;
            5'd6:    a = 6'd16;
            5'd7:    a = 6'd17;
            5'd8:    a = 6'd34;
            5'd9:    a = 6'd18;
            5'd10:   a = 6'd19;
            5'd11:   a = 6'd20;
            5'd12:   a = 6'd21;
            5'd13:   a = 6'd22;
            5'd14:   a = 6'd35;
            5'd15:   a = 6'd23;
            5'd16:   a = 6'd24;
            5'd17:   a = 6'd25;
            5'd18:   a = 6'd26;
            5'd19:   a = 6'd27;
            5'd20:   a = 6'd28;
            5'd21:   a = 6'd29;
            5'd22:   a = 6'd32;
            5'd23:   a = 6'd30;
            5'd24:   a = 6'd31;
            5'd25:   a = 6'd33;
            default: a = 6'd0;
        endcase
        return a;
    endfunction

`ifdef IDF_FORMAT_CHECK_EN
    always_comb begin
        fmt_err = (req_letter > 5'd25);
        for (int i = 0; i < 9; i++)
            if (req_digits[i*4 +: 4] > 4'd9) fmt_err = 1'b1;
    end
`else
    assign fmt_err = 1'b0;
`endif

    assign resp_valid = resp_q.valid;
    assign resp_legal = resp_q.legal;
    assign resp_err   = resp_q.err;

    // Every output is a flop; this block computes all next values.
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        tmo_d       = tmo_q;
        dig_d       = dig_q;
        req_ready_d = req_ready;
        civ_d       = chk_in_valid;
        cid_d       = chk_in_id;
        resp_d      = resp_q;
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    req_ready_d = 1'b0;
                    dig_d       = req_digits;
                    if (fmt_err) begin
                        state_d = RESP;
                        resp_d  = '{valid: 1'b1, legal: 1'b0, err: 1'b1};
                    end else begin
                        // Beat 0 goes out in the cycle right after accept.
                        state_d = SEND;
                        civ_d   = 1'b1;
                        cid_d   = area_code(req_letter);
                        beat_d  = 4'd1;
                    end
                end
            end
            SEND: begin
                if (beat_q == 4'd10) begin
                    civ_d   = 1'b0;
                    cid_d   = '0;
                    beat_d  = '0;
                    tmo_d   = '0;
                    state_d = WAIT;
                end else begin
                    // Digits leave MSB-first from a shift register.
                    cid_d  = {2'b00, dig_q[35:32]};
                    dig_d  = {dig_q[31:0], 4'h0};
                    beat_d = beat_q + 4'd1;
                end
            end
            WAIT: begin
                // A verdict arriving on the last allowed cycle beats the timeout.
                if (chk_out_valid) begin
                    resp_d  = '{valid: 1'b1, legal: chk_out_legal_id, err: 1'b0};
                    tmo_d   = '0;
                    state_d = RESP;
                end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    resp_d  = '{valid: 1'b1, legal: 1'b0, err: 1'b1};
                    tmo_d   = '0;
                    state_d = RESP;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            RESP: begin
                if (resp_ready) begin
                    resp_d      = '0;
                    req_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            beat_q       <= '0;
            tmo_q        <= '0;
            dig_q        <= '0;
            req_ready    <= 1'b1;
            chk_in_valid <= 1'b0;
            chk_in_id    <= '0;
            resp_q       <= '0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            tmo_q        <= tmo_d;
            dig_q        <= dig_d;
            req_ready    <= req_ready_d;
            chk_in_valid <= civ_d;
            chk_in_id    <= cid_d;
            resp_q       <= resp_d;
        end
    end

endmodule

// File: tb/tb_id_feeder.sv
// ---------------------------------------------------------------------------
// tb_id_feeder
//   Self-checking bench for id_feeder. A small checker stand-in consumes the
//   beat stream and answers after a programmable delay (or never). Expected
//   beats, latency and verdict come from a request-level reference model.
// ---------------------------------------------------------------------------
module tb_id_feeder;
    localparam int T = 16;

`ifdef IDF_FORMAT_CHECK_EN
    localparam bit FMT_ON = 1'b1;
`else
    localparam bit FMT_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [4:0]  req_letter = '0;
    logic [35:0] req_digits = '0;
    logic        chk_in_valid;
    logic [5:0]  chk_in_id;
    logic        chk_out_valid;
    logic        chk_out_legal_id;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic        resp_legal;
    logic        resp_err;

    always #5 clk = ~clk;

    id_feeder #(.TIMEOUT_CYCLES(T)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_letter       (req_letter),
        .req_digits       (req_digits),
        .chk_in_valid     (chk_in_valid),
        .chk_in_id        (chk_in_id),
        .chk_out_valid    (chk_out_valid),
        .chk_out_legal_id (chk_out_legal_id),
        .resp_valid       (resp_valid),
        .resp_ready       (resp_ready),
        .resp_legal       (resp_legal),
        .resp_err         (resp_err)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    int amap [26] = '{10, 11, 12, 13, 14, 15, 16, 17, 34, 18, 19, 20, 21,
                      22, 35, 23, 24, 25, 26, 27, 28, 29, 32, 30, 31, 33};

    // ---- checker stand-in: weighted sum of beats, verdict = sum%10==0 ----
    bit chk_en  = 1'b1;
    int chk_dly = 0;
    int sb_cnt, sb_sum, sb_wait;
    bit sb_pend;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_cnt <= 0; sb_sum <= 0; sb_wait <= 0; sb_pend <= 1'b0;
            chk_out_valid <= 1'b0; chk_out_legal_id <= 1'b0;
        end else begin
            chk_out_valid <= 1'b0;
            if (chk_in_valid) begin
                if (sb_cnt == 0)
                    sb_sum <= int'(chk_in_id) / 10 + (int'(chk_in_id) % 10) * 9;
                else
                    sb_sum <= sb_sum + int'(chk_in_id) * ((sb_cnt == 9) ? 1 : 9 - sb_cnt);
                sb_cnt <= sb_cnt + 1;
                if (sb_cnt == 9) begin
                    sb_pend <= 1'b1;
                    sb_wait <= chk_dly;
                end
            end else if (sb_pend) begin
                if (sb_wait == 0) begin
                    chk_out_valid    <= chk_en;
                    chk_out_legal_id <= (sb_sum % 10 == 0);
                    sb_pend <= 1'b0;
                    sb_cnt  <= 0;
                end else begin
                    sb_wait <= sb_wait - 1;
                end
            end
        end
    end

    // ---- request-level reference model ----
    function automatic int area_of(input int letter);
        return (letter <= 25) ? amap[letter] : 0;
    endfunction

    function automatic int nib(input logic [35:0] dig, input int k); // k = 1..9
        return int'(dig[(9-k)*4 +: 4]);
    endfunction

    function automatic int wsum(input int letter, input logic [35:0] dig);
        int a, s;
        a = area_of(letter);
        s = a / 10 + (a % 10) * 9;
        for (int k = 1; k <= 9; k++)
            s += nib(dig, k) * ((k == 9) ? 1 : 9 - k);
        return s;
    endfunction

    function automatic bit fmt_bad(input int letter, input logic [35:0] dig);
        bit b;
        b = (letter > 25);
        for (int k = 1; k <= 9; k++)
            if (nib(dig, k) > 9) b = 1'b1;
        return b && FMT_ON;
    endfunction

    // ---- stimulus helpers (entered and left on a falling edge) ----
    task automatic start_req(input int letter, input logic [35:0] dig);
        int w;
        w = 0;
        while (!req_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_letter = 5'(letter);
        req_digits = dig;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic run_req(input int letter, input logic [35:0] dig,
                           input bit en, input int dly, input int hold);
        int bq[$];
        int first, last, ridx, wc, got;
        bit exp_err, exp_legal;
        chk_en  = en;
        chk_dly = dly;
        start_req(letter, dig);
        first = -1; last = -1; ridx = -1;
        for (int c = 0; c < 200 && ridx < 0; c++) begin
            @(negedge clk);
            if (chk_in_valid) begin
                bq.push_back(int'(chk_in_id));
                if (first < 0) first = c;
                last = c;
            end
            if (resp_valid) ridx = c;
        end
        chk("resp_seen", 32'(ridx >= 0), 32'd1);
        if (fmt_bad(letter, dig)) begin
            exp_err = 1'b1; exp_legal = 1'b0;
            chk("fmt_no_beats", bq.size(), 0);
            chk("fmt_latency", ridx, 0);
        end else begin
            chk("beat_count", bq.size(), 10);
            for (int i = 0; i < 10; i++) begin
                got = (i < bq.size()) ? bq[i] : -1;
                chk($sformatf("beat%0d", i), got, (i == 0) ? area_of(letter) : nib(dig, i));
            end
            chk("first_beat_cycle", first, 0);
            chk("beat_span", last - first, 9);
            if (en && dly + 2 <= T) begin
                wc = dly + 2; exp_err = 1'b0; exp_legal = (wsum(letter, dig) % 10 == 0);
            end else begin
                wc = T; exp_err = 1'b1; exp_legal = 1'b0;
            end
            chk("wait_cycles", ridx - last - 1, wc);
        end
        chk("resp_err", 32'(resp_err), 32'(exp_err));
        chk("resp_legal", 32'(resp_legal), 32'(exp_legal));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            @(negedge clk);
            chk("hold_valid", 32'(resp_valid), 32'd1);
            chk("hold_legal", 32'(resp_legal), 32'(exp_legal));
            chk("hold_err", 32'(resp_err), 32'(exp_err));
            chk("hold_req_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk);
        #1 resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        @(negedge clk);
        chk("hs_valid_drop", 32'(resp_valid), 32'd0);
        chk("hs_req_ready", 32'(req_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [35:0] dig;
        int letter, s;

        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_civ", 32'(chk_in_valid), 32'd0);
        chk("rst_cid", 32'(chk_in_id), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_legal", 32'(resp_legal), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // basic legal ID, illegal check digit, letter I
        run_req(0, 36'h123456789, 1'b1, 0, 0);
        run_req(0, 36'h123456788, 1'b1, 2, 0);
        run_req(8, 36'h123456789, 1'b1, 1, 0);
        // checker silent -> timeout
        run_req(3, 36'h987654321, 1'b0, 0, 0);
        // verdict on the last WAIT cycle, and one cycle too late
        run_req(0, 36'h123456789, 1'b1, T - 2, 0);
        run_req(0, 36'h123456789, 1'b1, T - 1, 0);
        // backpressure on the response
        run_req(1, 36'h246813579, 1'b1, 0, 5);
        // out-of-range letter / digit
        run_req(26, 36'h123456789, 1'b1, 0, 0);
        run_req(2, 36'h12C456789, 1'b1, 0, 0);

        // reset during beat 4
        chk_en = 1'b1; chk_dly = 0;
        start_req(5, 36'h111111111);
        repeat (5) @(negedge clk);
        chk("pre_rst_civ", 32'(chk_in_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_civ", 32'(chk_in_valid), 32'd0);
        chk("mid_rst_cid", 32'(chk_in_id), 32'd0);
        chk("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("mid_rst_req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_req(0, 36'h123456789, 1'b1, 0, 0);

        // randomized requests
        for (int n = 0; n < 24; n++) begin
            letter = ($urandom_range(0, 7) == 0) ? int'($urandom_range(26, 31))
                                                 : int'($urandom_range(0, 25));
            for (int k = 0; k < 9; k++)
                dig[k*4 +: 4] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15))
                                                            : 4'($urandom_range(0, 9));
            if ($urandom_range(0, 1) == 1) begin
                dig[3:0] = 4'd0;
                s = wsum(letter, dig);
                dig[3:0] = 4'((10 - s % 10) % 10);
            end
            run_req(letter, dig, ($urandom_range(0, 5) != 0), int'($urandom_range(0, T)),
                    int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
